first_counter_sequencer: RTL and testbench

Upstream control stage for the 4-bit overflow counter. It turns start/stop/pause commands into a one-cycle clear followed by a prescaled train of single-cycle enable ticks, and drives the counter's `reset` and `enable` inputs. It ends a run after a programmed number of ticks, on a stop command, or (optionally) on the counter's overflow flag. It reports the outcome with a done pulse and a tick count.

---
 rtl/first_counter_seq_pkg.sv | 18 +
 rtl/prescale_tick_gen.sv | 46 ++++
 rtl/first_counter_sequencer.sv | 166 ++++++++++++++++
 tb/tb_first_counter_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/first_counter_seq_pkg.sv
// Shared types and default widths for the first_counter_sequencer block.
//   seq_state_t         : 3-bit sequencer state encoding
//   DEFAULT_PRESCALE_W  : default width of the prescale value
//   DEFAULT_LEN_W       : default width of burst length / tick counter
package first_counter_seq_pkg;

    localparam int unsigned DEFAULT_PRESCALE_W = 8;
    localparam int unsigned DEFAULT_LEN_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/prescale_tick_gen.sv
// Prescale down-counter producing the registered enable tick.
// cnt_q is the count of the current cycle; a RUN cycle at count 0 is a tick.
//   clk, reset : clock, async active-high reset
//   load       : load load_val (first RUN cycle follows)
//   load_val   : latched prescale, also the reload value after each tick
//   hold       : next cycle is not a RUN cycle; suppress the tick
//   run        : current cycle is a RUN cycle; consume one count
//   tick       : registered, high in RUN cycles whose count is 0
module prescale_tick_gen
    import first_counter_seq_pkg::*;
#(
    parameter int unsigned W = DEFAULT_PRESCALE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         hold,
    input  logic         run,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count for the next cycle; frozen whenever the current cycle is not RUN.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (run) begin
            cnt_d = (cnt_q == '0) ? load_val : cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tick  <= !hold && (cnt_d == '0);
        end
    end

endmodule

// File: rtl/first_counter_sequencer.sv
// Control stage for the 4-bit overflow counter: start/stop/pause commands
// become a one-cycle clear followed by prescaled single-cycle enable ticks.
// Optional feature macro: FIRST_COUNTER_SEQ_OVF_STOP_EN (end run on overflow_in).
//   clk, reset     : clock, async active-high reset
//   start/stop     : run commands; pause is a level hold request
//   prescale       : tick period minus 1, latched at start
//   burst_len      : ticks per run (0 = free-run), latched at start
//   overflow_in    : counter overflow flag
//   counter_clear  : one-cycle clear pulse to the counter
//   counter_enable : one-cycle enable tick
//   busy, done     : run in progress / one-cycle completion pulse
//   ticks_issued   : ticks completed in the current or last run
//   ovf_stop       : last run ended on overflow (sticky)
module first_counter_sequencer
    import first_counter_seq_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W,
    parameter int unsigned LEN_W      = DEFAULT_LEN_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [LEN_W-1:0]      burst_len,
    input  logic                  overflow_in,
    output logic                  counter_clear,
    output logic                  counter_enable,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-1:0]      ticks_issued,
    output logic                  ovf_stop
);

    seq_state_t            state_q;
    seq_state_t            state_d;
    logic [PRESCALE_W-1:0] pre_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      ticks_d;
    logic                  clear_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  ovf_d;
    logic                  ovf_hit_c;
    logic                  final_tick_c;
    logic                  launch_c;
    logic                  gen_load;
    logic                  gen_hold;
    logic                  gen_run;

`ifdef FIRST_COUNTER_SEQ_OVF_STOP_EN
    assign ovf_hit_c = overflow_in;
`else
    logic unused_overflow;
    assign unused_overflow = overflow_in;
    assign ovf_hit_c       = 1'b0;
`endif

    assign launch_c = (state_q == ST_IDLE) && start;

    // The tick in the current cycle is the one that completes the burst.
    assign final_tick_c = counter_enable && (len_q != '0) &&
                          (LEN_W'(ticks_issued + LEN_W'(1)) == len_q);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: stop > overflow > burst complete > pause.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = stop ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (stop || ovf_hit_c || final_tick_c) begin
                    state_d = ST_DONE;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (stop || ovf_hit_c) begin
                    state_d = ST_DONE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the next state.
    always_comb begin
        clear_d  = (state_d == ST_CLEAR);
        busy_d   = (state_d == ST_CLEAR) || (state_d == ST_RUN) || (state_d == ST_HOLD);
        done_d   = (state_d == ST_DONE);
        ticks_d  = ticks_issued;
        ovf_d    = ovf_stop;
        gen_load = (state_q == ST_CLEAR);
        gen_run  = (state_q == ST_RUN);
        gen_hold = (state_d != ST_RUN);
        if (launch_c) begin
            ticks_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (counter_enable) begin
                ticks_d = ticks_issued + LEN_W'(1);
            end
            if (((state_q == ST_RUN) || (state_q == ST_HOLD)) && !stop && ovf_hit_c) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Output and run-parameter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_clear <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ticks_issued  <= '0;
            ovf_stop      <= 1'b0;
            pre_q         <= '0;
            len_q         <= '0;
        end else begin
            counter_clear <= clear_d;
            busy          <= busy_d;
            done          <= done_d;
            ticks_issued  <= ticks_d;
            ovf_stop      <= ovf_d;
            if (launch_c) begin
                pre_q <= prescale;
                len_q <= burst_len;
            end
        end
    end

    prescale_tick_gen #(
        .W(PRESCALE_W)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (gen_load),
        .load_val (pre_q),
        .hold     (gen_hold),
        .run      (gen_run),
        .tick     (counter_enable)
    );

endmodule

// File: tb/tb_first_counter_sequencer.sv
// Self-checking bench for first_counter_sequencer: directed scenarios with
// literal expectations plus randomized stimulus against a cycle model.
module tb_first_counter_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic [7:0] prescale;
    logic [7:0] burst_len;
    logic       overflow_in;
    logic       counter_clear;
    logic       counter_enable;
    logic       busy;
    logic       done;
    logic [7:0] ticks_issued;
    logic       ovf_stop;

`ifdef FIRST_COUNTER_SEQ_OVF_STOP_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    first_counter_sequencer #(
        .PRESCALE_W(8),
        .LEN_W(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .pause          (pause),
        .prescale       (prescale),
        .burst_len      (burst_len),
        .overflow_in    (overflow_in),
        .counter_clear  (counter_clear),
        .counter_enable (counter_enable),
        .busy           (busy),
        .done           (done),
        .ticks_issued   (ticks_issued),
        .ovf_stop       (ovf_stop)
    );

    int vectors     = 0;
    int miscompares = 0;
    int edges       = 0;
    bit chk_en      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) edges <= edges + 1;

    // Cycle model: phase of the current cycle, RUN cycles elapsed in this run
    // (HOLD excluded), and ticks completed so far.
    typedef enum int {M_IDLE, M_CLEAR, M_RUN, M_HOLD, M_DONE} mphase_t;
    mphase_t    m_phase;
    int         m_p;
    int         m_k;
    logic [7:0] m_len;
    logic [7:0] m_ticks;
    bit         m_ovf;

    // A RUN cycle ticks when P RUN cycles have passed since the run began or
    // since the previous tick.
    function automatic bit m_tick();
        return (m_phase == M_RUN) && ((m_k % (m_p + 1)) == m_p);
    endfunction

    always @(posedge clk or posedge reset) begin : model
        bit t;
        bit ov;
        if (reset) begin
            m_phase <= M_IDLE;
            m_p     <= 0;
            m_k     <= 0;
            m_len   <= 8'd0;
            m_ticks <= 8'd0;
            m_ovf   <= 1'b0;
        end else begin
            t  = m_tick();
            ov = OVF_EN && overflow_in;
            case (m_phase)
                M_IDLE: if (start) begin
                    m_phase <= M_CLEAR;
                    m_p     <= int'(prescale);
                    m_len   <= burst_len;
                    m_ticks <= 8'd0;
                    m_ovf   <= 1'b0;
                    m_k     <= 0;
                end
                M_CLEAR: m_phase <= stop ? M_DONE : M_RUN;
                M_RUN: begin
                    m_k <= m_k + 1;
                    if (t) m_ticks <= m_ticks + 8'd1;
                    if (stop) m_phase <= M_DONE;
                    else if (ov) begin m_phase <= M_DONE; m_ovf <= 1'b1; end
                    else if (t && m_len != 0 && (m_ticks + 8'd1) == m_len) m_phase <= M_DONE;
                    else if (pause) m_phase <= M_HOLD;
                end
                M_HOLD: begin
                    if (stop) m_phase <= M_DONE;
                    else if (ov) begin m_phase <= M_DONE; m_ovf <= 1'b1; end
                    else if (!pause) m_phase <= M_RUN;
                end
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_clear",  counter_clear,  m_phase == M_CLEAR);
            chk("m_enable", counter_enable, m_tick());
            chk("m_busy",   busy,           m_phase inside {M_CLEAR, M_RUN, M_HOLD});
            chk("m_done",   done,           m_phase == M_DONE);
            chk("m_ticks",  ticks_issued,   m_ticks);
            chk("m_ovf",    ovf_stop,       m_ovf);
        end
    end

    // Called at a negedge: start sampled at the next edge; returns at the
    // negedge after that edge (the CLEAR cycle), with commands released.
    task automatic launch(input int p, input int l, input bit with_stop);
        prescale  = 8'(p);
        burst_len = 8'(l);
        start     = 1'b1;
        stop      = with_stop;
        @(negedge clk);
        start     = 1'b0;
        stop      = 1'b0;
        prescale  = 8'($urandom);
        burst_len = 8'($urandom);
    endtask

    task automatic scen_basic();
        launch(0, 4, 1'b0);
        chk("s1_clear", counter_clear, 1);
        chk("s1_busy",  busy, 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("s1_enable", counter_enable, 1);
            chk("s1_ticks_run", ticks_issued, 32'(i - 1));
        end
        @(negedge clk);
        chk("s1_done", done, 1);
        chk("s1_enable_off", counter_enable, 0);
        chk("s1_busy_off", busy, 0);
        chk("s1_ticks", ticks_issued, 4);
        @(negedge clk);
        chk("s1_done_pulse", done, 0);
        chk("s1_ticks_hold", ticks_issued, 4);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        overflow_in = 1'b0; prescale = 8'd0; burst_len = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_clear", counter_clear, 0);
        chk("rst_enable", counter_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ticks", ticks_issued, 0);
        chk("rst_ovf", ovf_stop, 0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Start sampled at edge 10.
        while (edges < 9) @(negedge clk);
        scen_basic();

        // prescale=2, burst_len=3: ticks 3 apart, done after the third.
        @(negedge clk);
        launch(2, 3, 1'b0);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            chk("s2_enable", counter_enable, (j == 3 || j == 6 || j == 9));
            chk("s2_done", done, (j == 10));
        end

        // prescale=3, pause for 5 cycles: second tick moves from j=8 to j=13.
        launch(3, 0, 1'b0);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            chk("s3_enable", counter_enable, (j == 4 || j == 13));
            if (j >= 6 && j <= 10) begin
                chk("s3_hold_ticks", ticks_issued, 1);
                chk("s3_hold_busy", busy, 1);
            end
            if (j == 15) begin
                chk("s3_done", done, 1);
                chk("s3_ticks", ticks_issued, 2);
            end
            if (j == 5)  pause = 1'b1;
            if (j == 10) pause = 1'b0;
            stop = (j == 14);
        end

        // start with stop in IDLE starts; free-run stopped after 20 ticks.
        launch(0, 0, 1'b1);
        chk("s4_clear", counter_clear, 1);
        for (int j = 1; j <= 21; j++) begin
            @(negedge clk);
            if (j <= 20) chk("s4_enable", counter_enable, 1);
            if (j == 21) begin
                chk("s4_done", done, 1);
                chk("s4_ticks", ticks_issued, 20);
            end
            stop = (j == 20);
        end
        stop = 1'b0;

        // Overflow during IDLE/CLEAR ignored; overflow in RUN ends run if enabled.
        @(negedge clk);
        overflow_in = 1'b1;
        launch(1, 0, 1'b0);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            overflow_in = (j == 3);
            if (j <= 3) chk("s5_clear_ovf_busy", busy, 1);
            if (j == 4) begin
                chk("s5_done", done, OVF_EN);
                chk("s5_ovf", ovf_stop, OVF_EN);
                chk("s5_busy", busy, !OVF_EN);
            end
            if (j == 5) chk("s5_ovf_sticky", ovf_stop, OVF_EN);
            stop = (j == 5);
        end
        stop = 1'b0;
        overflow_in = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-run, then the basic run again.
        launch(0, 10, 1'b0);
        repeat (3) @(negedge clk);
        chk("s6_pre_enable", counter_enable, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("s6_enable", counter_enable, 0);
        chk("s6_busy", busy, 0);
        chk("s6_clear", counter_clear, 0);
        chk("s6_done", done, 0);
        chk("s6_ticks", ticks_issued, 0);
        chk("s6_ovf", ovf_stop, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        scen_basic();

        // Randomized commands against the model.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            start       = ($urandom_range(0, 7) == 0);
            stop        = ($urandom_range(0, 40) == 0);
            overflow_in = ($urandom_range(0, 30) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            prescale    = 8'($urandom_range(0, 4));
            burst_len   = 8'($urandom_range(0, 12));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
